i2s_tx_scheduler: RTL
=====================

# i2s_tx_scheduler

- Frames and sequences the I2S transmit serializer in the audio output path, and shares that single serializer between two requesters: the left and right beamformer output streams.
- Accepts samples from each channel over a valid/ready handshake and holds them in a one-deep buffer per channel.
- Generates the word-select (ws) framing and issues one `ser_valid` strobe per slot to the serializer.
- Substitutes silence and flags an underrun when a channel has no sample ready at its slot boundary.

## Interface
- `BIT_WIDTH`, 24, audio sample width; must match the serializer.
- `SLOT_WIDTH`, 32, sck cycles per channel slot; legal range is `SLOT_WIDTH >= BIT_WIDTH+1`.
- `sck`  in  1  serial bit clock; sole clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run request, sampled only at frame boundaries.
- `l_data`  in  BIT_WIDTH  left sample.
- `l_valid`  in  1  left sample offered.
- `l_ready`  out  1  left buffer empty (`= !l_full`).
- `r_data`, `r_valid`, `r_ready`: same as left, for the right channel.
- `ws`  out  1  word select; 0 = left slot, 1 = right slot.
- `ser_sample`  out  BIT_WIDTH  sample to the serializer.
- `ser_valid`  out  1  one-cycle load strobe to the serializer.
- `underrun`  out  1  one-cycle pulse; the slot started with an empty buffer.
- `underrun_cnt`  out  16  saturating underrun count; present only with the macro.

## Operation
- **States:** IDLE, RUN. Registers: `bit_cnt` [$clog2(SLOT_WIDTH)-1:0], `ch` (0=L, 1=R), per-channel `buf`/`full`.
- **Reset values:**
  - State = IDLE; `bit_cnt`, `ch`, `ws`, `ser_valid`, `ser_sample`, `underrun`, `underrun_cnt` = 0.
  - `full` = 0, so `l_ready` = `r_ready` = 1.
- **Accept:** a channel accepts on an edge with `x_valid && x_ready`. That edge sets `buf <= x_data` and `full <= 1`. Buffers fill in both IDLE and RUN.
- **IDLE → RUN:** on an edge with `en=1`. That edge starts a left slot.
- **RUN, slot advance:** `bit_cnt` increments each edge. At `bit_cnt==SLOT_WIDTH-1` it wraps to 0 and `ch` toggles.
- **RUN → IDLE:** evaluated only at the edge ending a right slot (`ch=1`, `bit_cnt==SLOT_WIDTH-1`). If `en=0`, go to IDLE with `ws<=0`, `ch<=0`, `bit_cnt<=0`. Otherwise continue into the next left slot.
- **Slot start** (the IDLE→RUN edge, or any wrap edge that stays in RUN), with new channel `c`:
  - `ws <= c`, `ser_valid <= 1`.
  - If `full[c]`: `ser_sample <= buf[c]` and `full[c] <= 0`.
  - Otherwise: `ser_sample <= 0` and `underrun <= 1`.
- **All other edges:** `ser_valid <= 0`, `underrun <= 0`. `ser_sample` holds its value.
- **Simultaneous accept and start on an empty channel:** the slot underruns. The accepted sample stays buffered for that channel's next slot.
- **Accept while full:** cannot occur, because ready is low.
- **`en` dropped mid-frame:** the frame always completes, so the right slot is never truncated. Buffered samples are retained across IDLE.
- **Reset mid-frame:** all state returns to reset values immediately; buffered samples are discarded.

## Timing
- **Registered outputs:** `ws`, `ser_valid`, `ser_sample`, `underrun`.
- **Slot timing:** `ser_valid`=1 in the first cycle of every slot, coincident with the `ws` transition.
  - The serializer loads on the following edge, so the MSB appears on `sd` one sck after `ws` changes (standard I2S).
- **Frame period:** 2×SLOT_WIDTH sck.
- **Handshake latency:** sample accepted → transmitted at the next slot start of its channel. Worst case is 2×SLOT_WIDTH sck.
- **Ready:** `ready` rises on the edge that consumes the buffer. A new sample can therefore be accepted in the very next cycle.

## Configuration
- `I2S_TX_SCHED_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` port exists.
  - It increments on each underrun edge and saturates at 16'hFFFF.
  - It is cleared only by `rst`.
- Macro undefined: the port and counter are absent. The `underrun` pulse is unchanged.

## Structure
- **Package `i2s_pkg`:**
  - `ch_e` (`CH_LEFT=0`, `CH_RIGHT=1`).
  - `sched_state_e` (`S_IDLE`, `S_RUN`).
  - Default `I2S_SLOT_WIDTH=32` and `I2S_BIT_WIDTH=24` constants, shared with the serializer.
- **Sub-module `i2s_chan_buffer`:** one-deep valid/ready holding register with `take` input and `full`/`data` outputs. Instantiated twice (left, right).

## Test plan
- **Basic frame:** reset, preload L=24'hABCDEF and R=24'h123456, assert `en`.
  - Left slot: `ws`=0, `ser_valid` pulse with `ser_sample`=ABCDEF.
  - 32 cycles later: `ws`=1, `ser_valid` pulse with `ser_sample`=123456.
  - No `underrun`.
- **Underrun:** run with the right buffer never fed.
  - Every right slot: `ser_sample`=0, `ser_valid`=1, `underrun` pulse.
  - With the macro, `underrun_cnt` increments once per frame.
- **Same-edge collision:** present a left sample on exactly the left slot-start edge with the buffer empty.
  - That slot underruns.
  - The sample is transmitted in the next left slot, 64 cycles later.
- **Stop:** drop `en` at `bit_cnt`=5 of a left slot.
  - The left and right slots both complete.
  - `ws` returns to 0 and no further `ser_valid` occurs.
  - Buffered data is kept and sent after `en` is re-asserted.
- **Back-pressure:** hold `l_valid`=1 with a new sample each accept.
  - `l_ready` falls after the accept and rises only on the left slot-start edge.
  - Exactly one accept per frame.
- **Async reset:** assert `rst` mid-right-slot, between clock edges.
  - Outputs go to their reset values immediately.
  - After release with `en`=1, the first slot is left.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S transmit types and default geometry
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_e;

    localparam int I2S_SLOT_WIDTH = 32;
    localparam int I2S_BIT_WIDTH  = 24;

endpackage

// File: rtl/i2s_chan_buffer.sv
// rtl/i2s_chan_buffer.sv - one-deep valid/ready sample holding register
module i2s_chan_buffer
    import i2s_pkg::*;
#(
    parameter int BIT_WIDTH = I2S_BIT_WIDTH
) (
    input  logic                 sck,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 take,
    output logic                 full,
    output logic [BIT_WIDTH-1:0] data
);

    logic                 full_q, full_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;

    // take only happens while full and accept only while empty, so they never collide
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (take) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            data_d = in_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign data     = data_q;

endmodule

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S slot framing and L/R serializer sharing; I2S_TX_SCHED_UNDERRUN_CNT_EN adds underrun_cnt
module i2s_tx_scheduler
    import i2s_pkg::*;
#(
    parameter int BIT_WIDTH  = I2S_BIT_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
    input  logic                 sck,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] l_data,
    input  logic                 l_valid,
    output logic                 l_ready,
    input  logic [BIT_WIDTH-1:0] r_data,
    input  logic                 r_valid,
    output logic                 r_ready,
    output logic                 ws,
    output logic [BIT_WIDTH-1:0] ser_sample,
    output logic                 ser_valid,
    output logic                 underrun
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_WIDTH - 1);

    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    ch_e                  ch_q, ch_d;
    logic                 ws_q, ws_d;
    logic                 ser_valid_q, ser_valid_d;
    logic [BIT_WIDTH-1:0] ser_sample_q, ser_sample_d;
    logic                 underrun_q, underrun_d;

    logic                 slot_start;
    ch_e                  new_ch;
    logic                 l_take, r_take;
    logic                 l_full, r_full;
    logic [BIT_WIDTH-1:0] l_buf, r_buf;

    i2s_chan_buffer #(.BIT_WIDTH(BIT_WIDTH)) u_left (
        .sck      (sck),
        .rst      (rst),
        .in_data  (l_data),
        .in_valid (l_valid),
        .in_ready (l_ready),
        .take     (l_take),
        .full     (l_full),
        .data     (l_buf)
    );

    i2s_chan_buffer #(.BIT_WIDTH(BIT_WIDTH)) u_right (
        .sck      (sck),
        .rst      (rst),
        .in_data  (r_data),
        .in_valid (r_valid),
        .in_ready (r_ready),
        .take     (r_take),
        .full     (r_full),
        .data     (r_buf)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        ch_d         = ch_q;
        ws_d         = ws_q;
        ser_valid_d  = 1'b0;
        ser_sample_d = ser_sample_q;
        underrun_d   = 1'b0;
        slot_start   = 1'b0;
        new_ch       = CH_LEFT;
        l_take       = 1'b0;
        r_take       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d    = S_RUN;
                    bit_cnt_d  = '0;
                    ch_d       = CH_LEFT;
                    new_ch     = CH_LEFT;
                    slot_start = 1'b1;
                end
            end
            S_RUN: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    // stopping is only allowed once the right slot has fully gone out
                    if (ch_q == CH_RIGHT && !en) begin
                        state_d = S_IDLE;
                        ch_d    = CH_LEFT;
                        ws_d    = 1'b0;
                    end else begin
                        new_ch     = (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                        ch_d       = new_ch;
                        slot_start = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (slot_start) begin
            ws_d        = (new_ch == CH_RIGHT);
            ser_valid_d = 1'b1;
            if (new_ch == CH_LEFT) begin
                if (l_full) begin
                    ser_sample_d = l_buf;
                    l_take       = 1'b1;
                end else begin
                    ser_sample_d = '0;
                    underrun_d   = 1'b1;
                end
            end else begin
                if (r_full) begin
                    ser_sample_d = r_buf;
                    r_take       = 1'b1;
                end else begin
                    ser_sample_d = '0;
                    underrun_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            ch_q         <= CH_LEFT;
            ws_q         <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_sample_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ch_q         <= ch_d;
            ws_q         <= ws_d;
            ser_valid_q  <= ser_valid_d;
            ser_sample_q <= ser_sample_d;
            underrun_q   <= underrun_d;
        end
    end

    assign ws         = ws_q;
    assign ser_valid  = ser_valid_q;
    assign ser_sample = ser_sample_q;
    assign underrun   = underrun_q;

`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_d && underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
